// File: rtl/inv_add_key_stream.sv
// Decryption-side AddRoundKey engine: stores the forward-ordered expanded key and
// XORs round keys onto a byte-serial state stream in reverse round order.
module inv_add_key_stream #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clear,
  input  logic       key_wr_en,
  input  logic [7:0] key_wr_data,
  output logic       key_loaded,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_round,
  output logic       out_last
);

  localparam int unsigned KEY_BYTES = 16 * (NR + 1);
  localparam int unsigned AW        = $clog2(KEY_BYTES);
  localparam logic [3:0]  ROUND_MAX = 4'(NR);

  logic [7:0]    key_mem [KEY_BYTES];
  logic [AW-1:0] wr_ptr;
  logic [3:0]    round;
  logic [3:0]    byte_cnt;
  logic [AW-1:0] rd_addr;
  logic          wr_fire;
  logic          xfer;

  // Round-major addressing: 16*round + byte.
  assign rd_addr  = AW'({round, byte_cnt});
  assign in_ready = key_loaded && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign wr_fire  = key_wr_en && !key_loaded && !rst && !key_clear;

  // Key store is deliberately not reset; key_loaded gates every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      key_mem[wr_ptr] <= key_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || key_clear) begin
      key_loaded <= 1'b0;
      wr_ptr     <= '0;
      round      <= ROUND_MAX;
      byte_cnt   <= 4'd0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_round  <= 4'd0;
      out_last   <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (wr_ptr == AW'(KEY_BYTES - 1)) begin
          key_loaded <= 1'b1;
        end
      end

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ key_mem[rd_addr];
        out_round <= round;
        out_last  <= (round == 4'd0) && (byte_cnt == 4'd15);
        byte_cnt  <= byte_cnt + 4'd1;
        // Block end: round 0 wraps back to the final round key.
        if (byte_cnt == 4'd15) begin
          round <= (round == 4'd0) ? ROUND_MAX : round - 4'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inv_add_key_stream.sv
// Scoreboard bench for inv_add_key_stream: driver pushes expected bytes, monitor
// pops and compares on each output handshake.
module tb_inv_add_key_stream;

  localparam int unsigned NR        = 10;
  localparam int unsigned KEY_BYTES = 16 * (NR + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       key_clear;
  logic       key_wr_en;
  logic [7:0] key_wr_data;
  logic       key_loaded;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_round;
  logic       out_last;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] r;
    logic       l;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] kmodel [KEY_BYTES];
  int         mr = NR;
  int         mb = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  inv_add_key_stream #(.NR(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_clear  (key_clear),
    .key_wr_en  (key_wr_en),
    .key_wr_data(key_wr_data),
    .key_loaded (key_loaded),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_round  (out_round),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: an output is consumed at the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", int'(out_data), int'(e.d));
        chk("out_round", int'(out_round), int'(e.r));
        chk("out_last", int'(out_last), int'(e.l));
      end
    end
  end

  task automatic load_keys();
    for (int i = 0; i < int'(KEY_BYTES); i++) begin
      key_wr_en   = 1'b1;
      key_wr_data = kmodel[i];
      if (i == int'(KEY_BYTES) - 1) begin
        @(negedge clk);
        chk("key_loaded_before_last", int'(key_loaded), 0);
      end
      @(posedge clk);
      #1;
    end
    key_wr_en = 1'b0;
    @(negedge clk);
    chk("key_loaded_after_last", int'(key_loaded), 1);
    chk("in_ready_after_load", int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int t;
    exp_t e;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
    end else begin
      e.d = d ^ kmodel[16 * mr + mb];
      e.r = 4'(mr);
      e.l = (mr == 0) && (mb == 15);
      sb.push_back(e);
      if (mb == 15) begin
        mb = 0;
        mr = (mr == 0) ? int'(NR) : mr - 1;
      end else begin
        mb++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    key_clear   = 1'b0;
    key_wr_en   = 1'b0;
    key_wr_data = 8'd0;
    in_valid    = 1'b0;
    in_data     = 8'd0;
    out_ready   = 1'b1;

    @(posedge clk);
    @(negedge clk);
    chk("rst_key_loaded", int'(key_loaded), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_round", int'(out_round), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Forward-order load, key byte = address.
    for (int i = 0; i < int'(KEY_BYTES); i++) kmodel[i] = 8'(i);
    load_keys();

    // Full expansion of zeros: reverse round order, last flag on final byte.
    for (int i = 0; i < int'(KEY_BYTES); i++) send(8'h00);

    // Second pass starting with 0xFF, backpressure mid-round.
    for (int i = 0; i < int'(KEY_BYTES); i++) begin
      if (i == 5) begin
        exp_t held;
        held      = sb[$];
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_out_valid", int'(out_valid), 1);
          chk("bp_out_data_held", int'(out_data), int'(held.d));
          chk("bp_out_round_held", int'(out_round), int'(held.r));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      send((i == 0) ? 8'hFF : 8'(i * 7 + 3));
    end
    in_valid = 1'b0;

    // Writes after load must be ignored.
    key_wr_en   = 1'b1;
    key_wr_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    key_wr_en = 1'b0;
    @(negedge clk);
    chk("wr_after_load_key_loaded", int'(key_loaded), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) send(8'h00);

    // Mid-block clear with an output pending.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key_clear = 1'b1;
    @(posedge clk);
    #1;
    key_clear = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_key_loaded", int'(key_loaded), 0);
    chk("clr_in_ready", int'(in_ready), 0);
    chk("clr_out_data", int'(out_data), 0);
    chk("clr_out_round", int'(out_round), 0);
    void'(sb.pop_back());
    mr = NR;
    mb = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reload with a different key; first output must use round NR byte 0.
    for (int i = 0; i < int'(KEY_BYTES); i++) kmodel[i] = 8'(255 - i);
    load_keys();
    for (int i = 0; i < 16; i++) send(8'h00);
    in_valid = 1'b0;

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_add_key_stream.md
Name: inv_add_key_stream

Overview:
- Decryption-side AddRoundKey engine. It pairs with the key expansion, which writes all round keys in forward order (round 0 first).
- It reads the round keys back in reverse round order (round NR down to 0) and XORs them onto a byte-serial state stream.
- It sits between the inverse-round byte datapath and the key expansion output.
- Stores the full expanded key and has a valid/ready handshake on both sides.

Parameters:
- NR, 10: number of AES rounds (10/12/14). Key store depth = 16*(NR+1) bytes.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- key_clear, input, 1: synchronous invalidate of the stored key and counters.
- key_wr_en, input, 1: key byte write strobe.
- key_wr_data, input, 8: expanded-key byte; forward order, round 0 byte 0 first.
- key_loaded, output, 1: all 16*(NR+1) key bytes are stored.
- in_valid, input, 1: state byte valid.
- in_ready, output, 1: engine accepts a state byte this cycle.
- in_data, input, 8: state byte; column-major, byte 0 first within each round.
- out_valid, output, 1: output byte valid.
- out_ready, input, 1: downstream accepts the output byte.
- out_data, output, 8: in_data XOR round-key byte.
- out_round, output, 4: round index of the key applied to out_data.
- out_last, output, 1: out_data is byte 15 of round 0 (end of block).

Behaviour:
- Reset (rst=1): key_loaded=0, out_valid=0, out_data=0, out_round=0, out_last=0, write pointer=0, round counter=NR, byte counter=0.
  - Key store contents are not reset.
  - in_ready=0 while key_loaded=0.
- key_clear=1: same effect as rst on all state above. Takes priority over key_wr_en and over the stream handshake in the same cycle.
- Key load:
  - Each cycle with key_wr_en=1 and key_loaded=0 stores key_wr_data at the write pointer, then increments the pointer.
  - The write that stores address 16*(NR+1)-1 sets key_loaded=1 on the next clock edge.
  - key_wr_en while key_loaded=1 is ignored; no overwrite, no pointer change.
- Stream handshake:
  - in_ready = key_loaded AND (NOT out_valid OR out_ready).
  - Transfer when in_valid AND in_ready.
  - On a transfer:
    - out_data <= in_data XOR key[16*round + byte].
    - out_round <= round.
    - out_last <= (round==0 AND byte==15).
    - out_valid <= 1.
  - Latency: 1 cycle from input transfer to out_valid.
  - Output holds stable while out_valid=1 AND out_ready=0.
  - out_valid clears when out_ready=1 and no new transfer occurs in the same cycle.
  - Full throughput: one byte per cycle with continuous in_valid and out_ready.
- Counters (advance only on input transfer):
  - byte counts 0..15. On byte==15: byte wraps to 0 and round decrements.
  - round==0 with byte==15 wraps round to NR: the next byte starts a new block with the final round key.
- Widths: out_round is 4 bits wide. Key address fits ceil(log2(16*(NR+1))) bits. No arithmetic overflow beyond the defined wraps.
- Simultaneous key_wr_en and in_valid: cannot occur functionally, since in_ready=0 until loaded. Writes after load are ignored.
- key_clear or rst mid-block: the partial block is discarded, out_valid drops the next cycle, and a fresh key load is required.

Test Plan:
1. Forward-order key load:
   - Stimulus: rst, then write key bytes 0x00..0xAF (value = address, NR=10).
   - Response: key_loaded=1 one cycle after the 176th write; in_ready rises with it.
2. Reverse round order, zero input:
   - Stimulus: stream 176 bytes of 0x00 with out_ready=1.
   - Response:
     - Bytes 0-15 give out_data 0xA0..0xAF with out_round=10.
     - Bytes 160-175 give 0x00..0x0F with out_round=0.
     - out_last=1 only on the final byte (0x0F).
3. Block wrap:
   - Stimulus: stream a second block, byte 0 = 0xFF.
   - Response: out_data=0x5F (0xFF^0xA0), out_round=10, out_last=0.
4. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles mid-round.
   - Response: in_ready=0, out_data/out_round held unchanged, no byte lost or duplicated after out_ready returns to 1.
5. Write after load:
   - Stimulus: key_wr_en=1 with key_wr_data=0x55 after key_loaded=1.
   - Response: the next stream still gives 0xA0 for input 0x00 at round 10 byte 0.
6. Mid-block clear:
   - Stimulus: key_clear pulsed after 20 bytes.
   - Response: out_valid=0, key_loaded=0, in_ready=0 the next cycle. After a reload, the first output uses round 10 byte 0.
